// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Holds the FSM state enum, size defaults and row-major addressing.
package matmul_pkg;

  localparam int MAX_SIZE_DEF = 10;
  localparam int DATA_W_DEF   = 32;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  // Row-major address with a fixed pitch, independent of the run's N.
  function automatic int unsigned addr(
    input int unsigned row,
    input int unsigned col,
    input int unsigned pitch = MAX_SIZE_DEF
  );
    return row * pitch + col;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate with a one-cycle tag pipeline.
// Ports: clk, rst_n, in_valid/first (tag of issued pair), a/b, acc.
module matmul_mac #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              first,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc
);

  logic              r_vld;
  logic              r_first;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_prod;

  // Operands arrive one cycle after their address, so the
  // tag is delayed by one register to line up with them.
  assign w_prod = a * b;
  assign acc    = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_vld   <= in_valid;
      r_first <= first;
      if (r_vld) begin
        r_acc <= r_first ? w_prod : r_acc + w_prod;
      end
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B over row-major memories using one MAC.
// Ports: start/matrix_size in, busy/done/err out, A/B read, C write.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int MAX_SIZE = MAX_SIZE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = $clog2(MAX_SIZE * MAX_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       matrix_size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_rdata,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata
);

  localparam int CNT_W = $clog2(MAX_SIZE + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_i;
  logic [CNT_W-1:0] r_j;
  logic [CNT_W-1:0] r_k;
  logic             r_err;
  logic [CNT_W-1:0] w_n_m1;
  logic             w_legal;
  logic             w_k_last;
  logic             w_j_last;
  logic             w_i_last;
  logic             w_mac_vld;
  logic             w_mac_first;

  assign w_legal  = (matrix_size != 32'd0)
                 && (matrix_size <= 32'(MAX_SIZE));
  assign w_n_m1   = r_n - CNT_W'(1);
  assign w_k_last = (r_k == w_n_m1);
  assign w_j_last = (r_j == w_n_m1);
  assign w_i_last = (r_i == w_n_m1);

  // Counters only move in RUN/WRITE, so addresses hold elsewhere.
  assign a_addr = ADDR_W'(addr(32'(r_i), 32'(r_k), MAX_SIZE));
  assign b_addr = ADDR_W'(addr(32'(r_k), 32'(r_j), MAX_SIZE));
  assign c_addr = ADDR_W'(addr(32'(r_i), 32'(r_j), MAX_SIZE));

  assign w_mac_vld   = (r_state == RUN);
  assign w_mac_first = (r_k == '0);

  matmul_mac #(
    .DATA_W (DATA_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (w_mac_vld),
    .first    (w_mac_first),
    .a        (a_rdata),
    .b        (b_rdata),
    .acc      (c_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    c_we   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = w_legal ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_k_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        busy   = 1'b1;
        w_next = WRITE;
      end
      WRITE: begin
        busy   = 1'b1;
        c_we   = 1'b1;
        w_next = (w_i_last && w_j_last) ? DONE : RUN;
      end
      DONE: begin
        done   = 1'b1;
        err    = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n   <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_err <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_err <= !w_legal;
            if (w_legal) begin
              r_n <= matrix_size[CNT_W-1:0];
              r_i <= '0;
              r_j <= '0;
              r_k <= '0;
            end
          end
        end
        RUN: begin
          if (!w_k_last) begin
            r_k <= r_k + CNT_W'(1);
          end
        end
        WRITE: begin
          // Last element keeps its indices so addresses hold.
          if (!(w_i_last && w_j_last)) begin
            r_k <= '0;
            if (w_j_last) begin
              r_j <= '0;
              r_i <= r_i + CNT_W'(1);
            end else begin
              r_j <= r_j + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
